// File: rtl/phy_pattern_gen.sv
// Two-lane stimulus source: comma preamble, LFSR data bursts, comma gaps, then done.
// Latency: every output is registered and changes on the edge that enters its state.
// Backpressure: stall freezes state, counters, LFSR and outputs; enable=0 aborts to IDLE.
module phy_pattern_gen #(
  parameter int         SYNC_LEN   = 2,
  parameter int         BURST_LEN  = 4,
  parameter int         GAP_LEN    = 2,
  parameter int         NUM_BURSTS = 2,
  parameter logic [7:0] SEED       = 8'hA5
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       enable,
  input  logic       stall,
  output logic [7:0] data_out0,
  output logic [7:0] data_out1,
  output logic       valid_out0,
  output logic       valid_out1,
  output logic       done,
  output logic [7:0] word_count
);

  localparam int CW = 16;
  localparam logic [CW-1:0] SYNC_L  = CW'(SYNC_LEN);
  localparam logic [CW-1:0] BURST_L = CW'(BURST_LEN);
  localparam logic [CW-1:0] GAP_L   = CW'(GAP_LEN);
  localparam logic [CW-1:0] NB_L    = CW'(NUM_BURSTS);
  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [7:0]    SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0]    COMMA    = 8'hBC;

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_BURST, S_GAP, S_DONE} state_t;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;       // cycles spent in the current phase
  logic [CW-1:0] r_bcnt, w_bcnt_nx;     // completed bursts
  logic [7:0]    r_lfsr, w_lfsr_nx;     // next word to be emitted
  logic [7:0]    r_d0, w_d0_nx;
  logic [7:0]    r_d1, w_d1_nx;
  logic          r_vld, w_vld_nx;
  logic          r_done, w_done_nx;
  logic [7:0]    r_wc, w_wc_nx;
  logic          w_emit;
  logic          w_comma;

  // Next-state and next-output decode; defaults hold everything (covers stall).
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bcnt_nx  = r_bcnt;
    w_lfsr_nx  = r_lfsr;
    w_d0_nx    = r_d0;
    w_d1_nx    = r_d1;
    w_vld_nx   = r_vld;
    w_done_nx  = r_done;
    w_wc_nx    = r_wc;
    w_emit     = 1'b0;
    w_comma    = 1'b0;

    if (!enable) begin
      // Abort (or remain idle): the run restarts from scratch next time.
      w_state_nx = S_IDLE;
      w_cnt_nx   = '0;
      w_bcnt_nx  = '0;
      w_lfsr_nx  = SEED_EFF;
      w_d0_nx    = 8'h00;
      w_d1_nx    = 8'h00;
      w_vld_nx   = 1'b0;
      w_done_nx  = 1'b0;
      w_wc_nx    = 8'h00;
    end else if (stall && (r_state == S_SYNC || r_state == S_BURST || r_state == S_GAP)) begin
      // Frozen: defaults already hold every register.
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nx = S_SYNC;
          w_cnt_nx   = CW'(1);
          w_comma    = 1'b1;
        end
        S_SYNC: begin
          if (r_cnt == SYNC_L) begin
            w_state_nx = S_BURST;
            w_cnt_nx   = CW'(1);
            w_emit     = 1'b1;
          end else begin
            w_cnt_nx   = r_cnt + 1'b1;
            w_comma    = 1'b1;
          end
        end
        S_BURST: begin
          if (r_cnt == BURST_L) begin
            w_bcnt_nx = r_bcnt + 1'b1;
            if (r_bcnt + 1'b1 == NB_L) begin
              w_state_nx = S_DONE;
              w_d0_nx    = 8'h00;
              w_d1_nx    = 8'h00;
              w_vld_nx   = 1'b0;
              w_done_nx  = 1'b1;
            end else begin
              w_state_nx = S_GAP;
              w_cnt_nx   = CW'(1);
              w_comma    = 1'b1;
            end
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
            w_emit   = 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_L) begin
            w_state_nx = S_BURST;
            w_cnt_nx   = CW'(1);
            w_emit     = 1'b1;
          end else begin
            w_cnt_nx   = r_cnt + 1'b1;
            w_comma    = 1'b1;
          end
        end
        default: begin
          // DONE holds until enable drops.
        end
      endcase

      if (w_emit) begin
        w_d0_nx   = r_lfsr;
        w_d1_nx   = ~r_lfsr;
        w_vld_nx  = 1'b1;
        w_lfsr_nx = lfsr_step(r_lfsr);
        w_wc_nx   = r_wc + 8'd1;
      end
      if (w_comma) begin
        w_d0_nx  = COMMA;
        w_d1_nx  = COMMA;
        w_vld_nx = 1'b0;
      end
    end
  end

  // State and output registers with synchronous reset taking top priority.
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bcnt  <= '0;
      r_lfsr  <= SEED_EFF;
      r_d0    <= 8'h00;
      r_d1    <= 8'h00;
      r_vld   <= 1'b0;
      r_done  <= 1'b0;
      r_wc    <= 8'h00;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bcnt  <= w_bcnt_nx;
      r_lfsr  <= w_lfsr_nx;
      r_d0    <= w_d0_nx;
      r_d1    <= w_d1_nx;
      r_vld   <= w_vld_nx;
      r_done  <= w_done_nx;
      r_wc    <= w_wc_nx;
    end
  end

  assign data_out0  = r_d0;
  assign data_out1  = r_d1;
  assign valid_out0 = r_vld;
  assign valid_out1 = r_vld;
  assign done       = r_done;
  assign word_count = r_wc;

endmodule

// File: tb/tb_phy_pattern_gen.sv
// Bench for phy_pattern_gen: default instance plus a SEED=0 single-word instance.
// Expected outputs are queued per edge and compared one step after the rising edge.
// Covers reset, full run, stall hold, abort/restart, reset-over-stall, short config.
module tb_phy_pattern_gen;

  logic clk_8f = 1'b0;
  always #5 clk_8f = ~clk_8f;

  logic       reset, enable, stall;
  logic [7:0] d0_a, d1_a, wc_a, d0_b, d1_b, wc_b;
  logic       v0_a, v1_a, done_a, v0_b, v1_b, done_b;

  phy_pattern_gen dut_a (
    .clk_8f(clk_8f), .reset(reset), .enable(enable), .stall(stall),
    .data_out0(d0_a), .data_out1(d1_a), .valid_out0(v0_a), .valid_out1(v1_a),
    .done(done_a), .word_count(wc_a)
  );

  phy_pattern_gen #(.SEED(8'h00), .BURST_LEN(1), .NUM_BURSTS(1)) dut_b (
    .clk_8f(clk_8f), .reset(reset), .enable(enable), .stall(stall),
    .data_out0(d0_b), .data_out1(d1_b), .valid_out0(v0_b), .valid_out1(v1_b),
    .done(done_b), .word_count(wc_b)
  );

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] d0, d1, wc;
    logic       v, dn;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] seq [8] = '{8'hA5, 8'h4A, 8'h95, 8'h2A, 8'h54, 8'hA9, 8'h53, 8'hA7};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [7:0] d0, input logic [7:0] d1,
                      input logic v, input logic dn, input logic [7:0] wc);
    exp_t e;
    e.tag = tag; e.sel = sel; e.d0 = d0; e.d1 = d1; e.v = v; e.dn = dn; e.wc = wc;
    sb_q.push_back(e);
  endtask

  task automatic exp_idle(input string tag, input int sel);
    push(tag, sel, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask
  task automatic exp_comma(input string tag, input int sel, input logic [7:0] wc);
    push(tag, sel, 8'hBC, 8'hBC, 1'b0, 1'b0, wc);
  endtask
  task automatic exp_word(input string tag, input int sel, input logic [7:0] w, input logic [7:0] wc);
    push(tag, sel, w, ~w, 1'b1, 1'b0, wc);
  endtask
  task automatic exp_done(input string tag, input int sel, input logic [7:0] wc);
    push(tag, sel, 8'h00, 8'h00, 1'b0, 1'b1, wc);
  endtask

  // Advance one edge, then drain the scoreboard against the selected instance.
  task automatic tick();
    exp_t e;
    @(posedge clk_8f);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.sel == 0) begin
        check_val({e.tag, ".d0"}, 32'(d0_a), 32'(e.d0));
        check_val({e.tag, ".d1"}, 32'(d1_a), 32'(e.d1));
        check_val({e.tag, ".v0"}, 32'(v0_a), 32'(e.v));
        check_val({e.tag, ".v1"}, 32'(v1_a), 32'(e.v));
        check_val({e.tag, ".done"}, 32'(done_a), 32'(e.dn));
        check_val({e.tag, ".wc"}, 32'(wc_a), 32'(e.wc));
      end else begin
        check_val({e.tag, ".d0"}, 32'(d0_b), 32'(e.d0));
        check_val({e.tag, ".d1"}, 32'(d1_b), 32'(e.d1));
        check_val({e.tag, ".v0"}, 32'(v0_b), 32'(e.v));
        check_val({e.tag, ".v1"}, 32'(v1_b), 32'(e.v));
        check_val({e.tag, ".done"}, 32'(done_b), 32'(e.dn));
        check_val({e.tag, ".wc"}, 32'(wc_b), 32'(e.wc));
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; stall = 1'b0;

    // Reset state on both instances.
    exp_idle("rst_a", 0); exp_idle("rst_b", 1); tick();

    // Full unstalled run with default parameters.
    reset = 1'b0; enable = 1'b1;
    for (int i = 0; i < 2; i++) begin exp_comma("run_sync", 0, 8'd0); tick(); end
    for (int i = 0; i < 4; i++) begin exp_word("run_b0", 0, seq[i], 8'(i + 1)); tick(); end
    for (int i = 0; i < 2; i++) begin exp_comma("run_gap", 0, 8'd4); tick(); end
    for (int i = 4; i < 8; i++) begin exp_word("run_b1", 0, seq[i], 8'(i + 1)); tick(); end
    exp_done("run_done", 0, 8'd8); tick();
    exp_done("run_done_hold", 0, 8'd8); tick();

    // Drop enable from DONE.
    enable = 1'b0;
    exp_idle("done_exit", 0); tick();

    // Stall for 3 edges while 95 is presented.
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin exp_comma("st_sync", 0, 8'd0); tick(); end
    for (int i = 0; i < 3; i++) begin exp_word("st_b0", 0, seq[i], 8'(i + 1)); tick(); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin exp_word("st_hold", 0, 8'h95, 8'd3); tick(); end
    stall = 1'b0;
    exp_word("st_after", 0, 8'h2A, 8'd4); tick();
    for (int i = 0; i < 2; i++) begin exp_comma("st_gap", 0, 8'd4); tick(); end
    for (int i = 4; i < 8; i++) begin exp_word("st_b1", 0, seq[i], 8'(i + 1)); tick(); end
    exp_done("st_done", 0, 8'd8); tick();

    // Abort during the first gap, then restart from the preamble.
    enable = 1'b0; exp_idle("ab_idle0", 0); tick();
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin exp_comma("ab_sync", 0, 8'd0); tick(); end
    for (int i = 0; i < 4; i++) begin exp_word("ab_b0", 0, seq[i], 8'(i + 1)); tick(); end
    exp_comma("ab_gap", 0, 8'd4); tick();
    enable = 1'b0; exp_idle("ab_abort", 0); tick();
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin exp_comma("ab_resync", 0, 8'd0); tick(); end
    exp_word("ab_restart", 0, 8'hA5, 8'd1); tick();
    exp_word("ab_next", 0, 8'h4A, 8'd2); tick();

    // Reset together with stall mid-burst: reset wins.
    reset = 1'b1; stall = 1'b1;
    exp_idle("rs_win", 0); tick();
    // Stall is ignored in IDLE, so the run still starts.
    reset = 1'b0;
    exp_comma("rs_idle_stall", 0, 8'd0); tick();
    stall = 1'b0;
    exp_comma("rs_sync", 0, 8'd0); tick();
    exp_word("rs_reseed", 0, 8'hA5, 8'd1); tick();

    // Short configuration: SEED=0, one single-word burst.
    reset = 1'b1; enable = 1'b0;
    exp_idle("sh_rst", 1); tick();
    reset = 1'b0; enable = 1'b1;
    for (int i = 0; i < 2; i++) begin exp_comma("sh_sync", 1, 8'd0); tick(); end
    exp_word("sh_word", 1, 8'h01, 8'd1); tick();
    exp_done("sh_done", 1, 8'd1); tick();
    enable = 1'b0;
    exp_idle("sh_exit", 1); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
